// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between pipeline writeback (priority) and
// a buffered multi-cycle unit, with an age-based writeback bubble against starvation.
module regfile_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wb_valid,
  input  logic [4:0]                   wb_reg,
  input  logic [63:0]                  wb_data,
  input  logic                         mc_valid,
  output logic                         mc_ready,
  input  logic [4:0]                   mc_reg,
  input  logic [63:0]                  mc_data,
  output logic                         stall_wb,
  output logic                         RegWrite,
  output logic [4:0]                   WriteRegister,
  output logic [63:0]                  WriteData,
  output logic [31:0]                  busy_mask,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(MAX_WAIT + 1);
  localparam logic [OW-1:0] DEPTH_C    = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [AW-1:0] MAX_WAIT_C = AW'(MAX_WAIT);

  logic [4:0]       fifo_reg  [DEPTH];
  logic [63:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic [PW-1:0]    head, tail;
  logic [OW-1:0]    occ;
  logic [AW-1:0]    age;
  logic             fifo_empty, push, pop;
  logic             sel_valid;

  assign fifo_empty = (occ == '0);
  assign mc_ready   = (occ < DEPTH_C);
  // Register 31 completes the handshake but is dropped rather than buffered.
  assign push       = mc_valid && mc_ready && (mc_reg != 5'd31);
  assign pop        = !wb_valid && !fifo_empty;
  assign stall_wb   = (age == MAX_WAIT_C);
  assign occupancy  = occ;

  always_comb begin
    sel_valid     = 1'b0;
    WriteRegister = '0;
    WriteData     = '0;
    if (wb_valid) begin
      sel_valid     = 1'b1;
      WriteRegister = wb_reg;
      WriteData     = wb_data;
    end else if (!fifo_empty) begin
      sel_valid     = 1'b1;
      WriteRegister = fifo_reg[head];
      WriteData     = fifo_data[head];
    end
  end

  assign RegWrite = reset_n && sel_valid && (WriteRegister != 5'd31);

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i]) busy_mask[fifo_reg[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_reg[tail]  <= mc_reg;
      fifo_data[tail] <= mc_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head      <= '0;
      tail      <= '0;
      occ       <= '0;
      age       <= '0;
      entry_vld <= '0;
    end else begin
      if (pop) begin
        entry_vld[head] <= 1'b0;
        head            <= (head == LAST_PTR) ? '0 : head + PW'(1);
      end
      if (push) begin
        entry_vld[tail] <= 1'b1;
        tail            <= (tail == LAST_PTR) ? '0 : tail + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
      if (fifo_empty || pop) age <= '0;
      else if (age != MAX_WAIT_C) age <= age + AW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_reg;
  logic [63:0] mc_data;
  logic        stall_wb;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [31:0] busy_mask;
  logic [1:0]  occupancy;

  int checks = 0;
  int fails  = 0;

  regfile_write_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg(mc_reg), .mc_data(mc_data),
    .stall_wb(stall_wb), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .busy_mask(busy_mask), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 64'h99;
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 64'h33;
    #1;
    checks++; if (mc_ready !== 1'b1) begin fails++; $display("FAIL reset_mc_ready: got %b expected 1", mc_ready); end
    checks++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL reset_regwrite: got %b expected 0", RegWrite); end
    tick(); tick();
    checks++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    checks++; if (stall_wb !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall_wb); end
    reset_n = 1'b1; mc_valid = 1'b0; wb_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL idle_regwrite[%0d]: got %b expected 0", i, RegWrite); end
      checks++; if (occupancy !== 2'd0 || busy_mask !== 32'h0) begin
        fails++; $display("FAIL idle_state[%0d]: got occ=%0d busy=%h expected occ=0 busy=0", i, occupancy, busy_mask); end
      tick();
    end
    checks++; if (WriteRegister !== 5'd0 || WriteData !== 64'h0) begin
      fails++; $display("FAIL idle_port: got reg=%0d data=%h expected 0/0", WriteRegister, WriteData); end
  endtask

  task automatic test_single_push();
    mc_valid = 1'b1; mc_reg = 5'd5; mc_data = 64'hAB; wb_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL push_no_bypass: got %b expected 0", RegWrite); end
    tick();
    mc_valid = 1'b0;
    #1;
    checks++; if (busy_mask !== 32'h20) begin fails++; $display("FAIL push_busy: got %h expected 00000020", busy_mask); end
    checks++; if (occupancy !== 2'd1) begin fails++; $display("FAIL push_occ: got %0d expected 1", occupancy); end
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd5 || WriteData !== 64'hAB) begin
      fails++; $display("FAIL push_drain: got we=%b reg=%0d data=%h expected 1/5/ab", RegWrite, WriteRegister, WriteData); end
    tick();
    checks++; if (busy_mask !== 32'h0 || occupancy !== 2'd0 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL push_after: got busy=%h occ=%0d we=%b expected 0/0/0", busy_mask, occupancy, RegWrite); end
  endtask

  task automatic test_priority_starvation();
    mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 64'h77; wb_valid = 1'b0;
    tick();
    mc_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 64'h33;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 64'h33 || stall_wb !== 1'b0) begin
        fails++; $display("FAIL prio_wb[%0d]: got we=%b reg=%0d data=%h stall=%b expected 1/3/33/0",
                          i, RegWrite, WriteRegister, WriteData, stall_wb); end
      tick();
    end
    checks++; if (stall_wb !== 1'b1) begin fails++; $display("FAIL prio_stall: got %b expected 1", stall_wb); end
    // Protocol violation: wb keeps winning and the stall holds.
    checks++; if (WriteRegister !== 5'd3) begin fails++; $display("FAIL violation_wb_wins: got %0d expected 3", WriteRegister); end
    tick();
    checks++; if (stall_wb !== 1'b1 || occupancy !== 2'd1) begin
      fails++; $display("FAIL violation_hold: got stall=%b occ=%0d expected 1/1", stall_wb, occupancy); end
    wb_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd7 || WriteData !== 64'h77) begin
      fails++; $display("FAIL prio_drain: got we=%b reg=%0d data=%h expected 1/7/77", RegWrite, WriteRegister, WriteData); end
    tick();
    checks++; if (stall_wb !== 1'b0 || occupancy !== 2'd0) begin
      fails++; $display("FAIL prio_after: got stall=%b occ=%0d expected 0/0", stall_wb, occupancy); end
  endtask

  task automatic test_full();
    wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 64'h33;
    mc_valid = 1'b1; mc_reg = 5'd10; mc_data = 64'hA0;
    tick();
    mc_reg = 5'd11; mc_data = 64'hB1;
    #1;
    checks++; if (mc_ready !== 1'b1) begin fails++; $display("FAIL full_ready1: got %b expected 1", mc_ready); end
    tick();
    mc_reg = 5'd12; mc_data = 64'hC2;
    #1;
    checks++; if (occupancy !== 2'd2 || mc_ready !== 1'b0) begin
      fails++; $display("FAIL full_occ: got occ=%0d ready=%b expected 2/0", occupancy, mc_ready); end
    checks++; if (busy_mask !== 32'h0000_0C00) begin fails++; $display("FAIL full_busy: got %h expected 00000c00", busy_mask); end
    wb_valid = 1'b0;
    #1;
    checks++; if (mc_ready !== 1'b0 || WriteRegister !== 5'd10) begin
      fails++; $display("FAIL full_no_credit: got ready=%b reg=%0d expected 0/10", mc_ready, WriteRegister); end
    tick();
    checks++; if (occupancy !== 2'd1 || mc_ready !== 1'b1 || WriteRegister !== 5'd11 || WriteData !== 64'hB1) begin
      fails++; $display("FAIL full_after_pop: got occ=%0d ready=%b reg=%0d data=%h expected 1/1/11/b1",
                        occupancy, mc_ready, WriteRegister, WriteData); end
    tick();
    mc_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd1 || WriteRegister !== 5'd12 || WriteData !== 64'hC2 || busy_mask !== 32'h1000) begin
      fails++; $display("FAIL full_third: got occ=%0d reg=%0d data=%h busy=%h expected 1/12/c2/00001000",
                        occupancy, WriteRegister, WriteData, busy_mask); end
    tick();
    checks++; if (occupancy !== 2'd0 || stall_wb !== 1'b0) begin
      fails++; $display("FAIL full_drained: got occ=%0d stall=%b expected 0/0", occupancy, stall_wb); end
  endtask

  task automatic test_reg31();
    wb_valid = 1'b1; wb_reg = 5'd31; wb_data = 64'hFF;
    #1;
    checks++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL r31_wb: got %b expected 0", RegWrite); end
    wb_valid = 1'b0; mc_valid = 1'b1; mc_reg = 5'd31; mc_data = 64'hEE;
    #1;
    checks++; if (mc_ready !== 1'b1) begin fails++; $display("FAIL r31_ready: got %b expected 1", mc_ready); end
    tick();
    mc_valid = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || RegWrite !== 1'b0 || busy_mask !== 32'h0) begin
      fails++; $display("FAIL r31_mc: got occ=%0d we=%b busy=%h expected 0/0/0", occupancy, RegWrite, busy_mask); end
  endtask

  task automatic test_simul_reset();
    mc_valid = 1'b1; mc_reg = 5'd4; mc_data = 64'h44; wb_valid = 1'b0;
    tick();
    mc_reg = 5'd6; mc_data = 64'h66;
    #1;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd4 || WriteData !== 64'h44) begin
      fails++; $display("FAIL sim_pop: got we=%b reg=%0d data=%h expected 1/4/44", RegWrite, WriteRegister, WriteData); end
    tick();
    mc_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 64'h22;
    #1;
    checks++; if (occupancy !== 2'd1 || busy_mask !== 32'h40 || WriteRegister !== 5'd2) begin
      fails++; $display("FAIL sim_pushpop: got occ=%0d busy=%h reg=%0d expected 1/00000040/2",
                        occupancy, busy_mask, WriteRegister); end
    reset_n = 1'b0;
    #1;
    checks++; if (occupancy !== 2'd0 || busy_mask !== 32'h0 || RegWrite !== 1'b0) begin
      fails++; $display("FAIL sim_reset: got occ=%0d busy=%h we=%b expected 0/0/0", occupancy, busy_mask, RegWrite); end
    #1;
    reset_n = 1'b1; wb_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0) begin fails++; $display("FAIL sim_discard: got %b expected 0", RegWrite); end
    tick();
    checks++; if (RegWrite !== 1'b0 || occupancy !== 2'd0) begin
      fails++; $display("FAIL sim_discard2: got we=%b occ=%0d expected 0/0", RegWrite, occupancy); end
    mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 64'h99;
    tick();
    mc_valid = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd9 || WriteData !== 64'h99) begin
      fails++; $display("FAIL sim_recover: got we=%b reg=%0d data=%h expected 1/9/99", RegWrite, WriteRegister, WriteData); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_push();
    test_priority_starvation();
    test_full();
    test_reg31();
    test_simul_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
